activation_pipe: RTL

ACTIVATION_PIPE -- requirements
Module: activation_pipe

---
 rtl/activation_pipe.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/activation_pipe.sv
// rtl/activation_pipe.sv - three-stage LUT-interpolated activation pipeline (relu/tanh/sigmoid/identity)
module activation_pipe #(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 16,
  parameter int LUT_ADDR  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic [1:0]              in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  input  logic                    lut_we,
  input  logic [LUT_ADDR-1:0]     lut_addr,
  input  logic signed [WIDTH-1:0] lut_wdata,
  output logic [15:0]             clamp_count
);

  localparam int LUT_SIZE = 1 << LUT_ADDR;
  // Each LUT segment covers 2^SEG raw steps so that LUT_SIZE segments span [-8.0, 8.0).
  localparam int SEG      = FRAC_BITS + 4 - LUT_ADDR;

  localparam logic [1:0] MODE_RELU  = 2'd0;
  localparam logic [1:0] MODE_TANH  = 2'd1;
  localparam logic [1:0] MODE_SIGM  = 2'd2;
  localparam logic [1:0] MODE_IDENT = 2'd3;

  localparam logic signed [WIDTH:0] T_HI  = {{(WIDTH-FRAC_BITS-3){1'b0}}, 4'b1000, {FRAC_BITS{1'b0}}};
  localparam logic signed [WIDTH:0] T_LO  = -T_HI;
  localparam logic signed [WIDTH:0] ONE_W = {{(WIDTH-FRAC_BITS){1'b0}}, 1'b1, {FRAC_BITS{1'b0}}};

  logic [WIDTH-1:0] lut [LUT_SIZE];

  logic adv;
  logic accept;

  // Stage 1 registers: mode, raw sample, LUT index and segment fraction
  logic                    s1_valid;
  logic [1:0]              s1_mode;
  logic signed [WIDTH-1:0] s1_x;
  logic [LUT_ADDR-1:0]     s1_idx;
  logic [SEG-1:0]          s1_frac;

  // Stage 2 registers: the two bracketing LUT entries
  logic                    s2_valid;
  logic [1:0]              s2_mode;
  logic signed [WIDTH-1:0] s2_x;
  logic signed [WIDTH-1:0] s2_y0;
  logic signed [WIDTH-1:0] s2_y1;
  logic [SEG-1:0]          s2_frac;

  // Stage 1 combinational address generation
  logic signed [WIDTH-1:0] t;
  logic signed [WIDTH:0]   t_ext;
  logic                    clamp_lo;
  logic                    clamp_hi;
  logic                    lut_mode;
  logic [LUT_ADDR-1:0]     idx_d;
  logic [SEG-1:0]          frac_d;

  // Stage 3 combinational interpolation and post-scale
  logic signed [WIDTH:0]       diff;
  logic signed [WIDTH+SEG:0]   diff_w;
  logic signed [WIDTH+SEG:0]   frac_w;
  logic signed [WIDTH+SEG:0]   prod;
  logic signed [WIDTH:0]       y;
  logic signed [WIDTH:0]       sum;
  logic signed [WIDTH:0]       sig;
  logic signed [WIDTH:0]       res;
  logic                        unused_bits;

  function automatic logic [WIDTH-1:0] sat(input logic [WIDTH:0] v);
    if (v[WIDTH] != v[WIDTH-1]) begin
      return v[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    return v[WIDTH-1:0];
  endfunction

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv && !rst;

  // Map the sample to a LUT segment; the +LUT_SIZE/2 offset is just an MSB flip of the shifted value
  always_comb begin
    t        = (in_mode == MODE_SIGM) ? (in_data >>> 1) : in_data;
    t_ext    = {t[WIDTH-1], t};
    lut_mode = (in_mode == MODE_TANH) || (in_mode == MODE_SIGM);
    clamp_lo = t_ext < T_LO;
    clamp_hi = t_ext >= T_HI;
    idx_d    = {~t[SEG+LUT_ADDR-1], t[SEG+LUT_ADDR-2:SEG]};
    frac_d   = t[SEG-1:0];
    if (clamp_lo) begin
      idx_d  = '0;
      frac_d = '0;
    end else if (clamp_hi) begin
      idx_d  = '1;
      frac_d = '0;
    end
  end

  // Linear interpolation between y0 and y1, then mode-dependent result selection
  always_comb begin
    diff        = {s2_y1[WIDTH-1], s2_y1} - {s2_y0[WIDTH-1], s2_y0};
    diff_w      = {{SEG{diff[WIDTH]}}, diff};
    frac_w      = {{(WIDTH+1){1'b0}}, s2_frac};
    prod        = diff_w * frac_w;
    y           = {s2_y0[WIDTH-1], s2_y0} + prod[WIDTH+SEG:SEG];
    sum         = y + ONE_W;
    sig         = {sum[WIDTH], sum[WIDTH:1]};
    unused_bits = ^{prod[SEG-1:0], sum[0]};
    case (s2_mode)
      MODE_RELU:  res = s2_x[WIDTH-1] ? '0 : {1'b0, s2_x};
      MODE_TANH:  res = y;
      MODE_SIGM:  res = sig;
      default:    res = {s2_x[WIDTH-1], s2_x};
    endcase
  end

  // Advance all three stages together whenever the output slot is free
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_mode   <= '0;
      s1_x      <= '0;
      s1_idx    <= '0;
      s1_frac   <= '0;
      s2_valid  <= 1'b0;
      s2_mode   <= '0;
      s2_x      <= '0;
      s2_y0     <= '0;
      s2_y1     <= '0;
      s2_frac   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_mode   <= in_mode;
      s1_x      <= in_data;
      s1_idx    <= idx_d;
      s1_frac   <= frac_d;
      s2_valid  <= s1_valid;
      s2_mode   <= s1_mode;
      s2_x      <= s1_x;
      s2_y0     <= lut[s1_idx];
      s2_y1     <= (s1_idx == '1) ? lut[s1_idx] : lut[s1_idx + LUT_ADDR'(1)];
      s2_frac   <= s1_frac;
      out_valid <= s2_valid;
      out_data  <= sat(res);
    end
  end

  // LUT write port; a read on the same edge sees the previous contents
  always_ff @(posedge clk) begin
    if (!rst && lut_we) begin
      lut[lut_addr] <= lut_wdata;
    end
  end

  // Saturating count of LUT-mode samples that fell outside [-8.0, 8.0)
  always_ff @(posedge clk) begin
    if (rst) begin
      clamp_count <= '0;
    end else if (accept && lut_mode && (clamp_lo || clamp_hi) && (clamp_count != 16'hFFFF)) begin
      clamp_count <= clamp_count + 16'd1;
    end
  end

endmodule
